// File: rtl/fpu_seq.sv
// ----------------------------------------------------------------------------
// fpu_seq
// Multi-cycle FPU issue sequencer. Accepts one FP operation per valid/ready
// handshake and registers its opcode and operands onto the shared FP units.
// Those registers hold steady for a per-class latency. The unit result is then
// captured and returned with the caller's tag through a valid/ready output.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   in_valid/ready  request handshake (in_op, in_src0/1, in_tag)
//   flush           synchronous discard of any in-flight or held operation
//   unit_op/src0/1  registered op/operands to the FP units (stable in EXEC)
//   unit_res        FP unit result, selected externally by unit_op
//   out_valid/ready result handshake (out_result, out_tag, out_illegal)
//   busy            sequencer not idle
//   ops_done        completed output handshakes, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module fpu_seq #(
    parameter int TAG_W    = 4,
    parameter int CNT_W    = 32,
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 4,
    parameter int LAT_SQRT = 4,
    parameter int LAT_CVT  = 2,
    parameter int LAT_MISC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_src0,
    input  logic [31:0]      in_src1,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [3:0]       unit_op,
    output logic [31:0]      unit_src0,
    output logic [31:0]      unit_src1,
    input  logic [31:0]      unit_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_DIV   = 4'd3,
        OP_SQRT  = 4'd4,
        OP_SGNJ  = 4'd5,
        OP_SGNJN = 4'd6,
        OP_SGNJX = 4'd7,
        OP_FEQ   = 4'd8,
        OP_FLE   = 4'd9,
        OP_FLT   = 4'd10,
        OP_CVTWS = 4'd11,
        OP_CVTSW = 4'd12
    } op_e;

    state_e           r_state;
    state_e           w_next;
    logic [3:0]       r_cnt;
    logic [3:0]       r_unit_op;
    logic [31:0]      r_unit_src0;
    logic [31:0]      r_unit_src1;
    logic [31:0]      r_out_result;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_illegal;
    logic [CNT_W-1:0] r_ops_done;

    logic             w_accept;
    logic             w_out_hs;
    logic             w_in_illegal;
    logic             w_is_cmp;
    logic [3:0]       w_lat;

    function automatic logic [3:0] f_lat(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB:     f_lat = 4'(LAT_ADD);
            OP_MUL:             f_lat = 4'(LAT_MUL);
            OP_DIV:             f_lat = 4'(LAT_DIV);
            OP_SQRT:            f_lat = 4'(LAT_SQRT);
            OP_CVTWS, OP_CVTSW: f_lat = 4'(LAT_CVT);
            default:            f_lat = 4'(LAT_MISC);
        endcase
    endfunction

    assign w_in_illegal = (in_op > OP_CVTSW);
    assign w_lat        = f_lat(in_op);
    assign w_is_cmp     = (r_unit_op == OP_FEQ) || (r_unit_op == OP_FLE) ||
                          (r_unit_op == OP_FLT);

    // A held result can hand over to a new request in the same cycle it is
    // consumed; flush blocks both directions of the handshake.
    assign in_ready = !flush && ((r_state == S_IDLE) ||
                                 ((r_state == S_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = (r_state == S_DONE) && out_ready && !flush;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_in_illegal ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_next = w_in_illegal ? S_DONE : S_EXEC;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_unit_op     <= '0;
            r_unit_src0   <= '0;
            r_unit_src1   <= '0;
            r_out_result  <= '0;
            r_out_tag     <= '0;
            r_out_illegal <= 1'b0;
            r_ops_done    <= '0;
        end else begin
            r_state <= w_next;
            if (!flush) begin
                if (w_accept) begin
                    r_out_tag <= in_tag;
                    if (w_in_illegal) begin
                        // Illegal ops never reach the units; unit_* keep the
                        // previous op so the FP datapath sees no spurious change.
                        r_out_result  <= '0;
                        r_out_illegal <= 1'b1;
                    end else begin
                        r_unit_op     <= in_op;
                        r_unit_src0   <= in_src0;
                        r_unit_src1   <= in_src1;
                        r_cnt         <= w_lat;
                        r_out_illegal <= 1'b0;
                    end
                end else if (r_state == S_EXEC) begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_out_result <= w_is_cmp ? {31'b0, unit_res[0]} : unit_res;
                    end
                end
                if (w_out_hs) begin
                    r_ops_done <= r_ops_done + CNT_W'(1);
                end
            end
        end
    end

    assign unit_op     = r_unit_op;
    assign unit_src0   = r_unit_src0;
    assign unit_src1   = r_unit_src1;
    assign out_valid   = (r_state == S_DONE);
    assign out_result  = r_out_result;
    assign out_tag     = r_out_tag;
    assign out_illegal = r_out_illegal;
    assign busy        = (r_state != S_IDLE);
    assign ops_done    = r_ops_done;

endmodule

// File: tb/tb_fpu_seq.sv
// ----------------------------------------------------------------------------
// tb_fpu_seq
// Directed bench for fpu_seq. The FP units are modelled as a result that only
// becomes correct a programmable number of cycles after an op is accepted
// (0xDEADBEEF before that). ops_done is narrowed to 4 bits so the wrap from
// all-ones to zero is reachable in a short run.
// ----------------------------------------------------------------------------
module tb_fpu_seq;

    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [31:0]      in_src0;
    logic [31:0]      in_src1;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic [3:0]       unit_op;
    logic [31:0]      unit_src0;
    logic [31:0]      unit_src1;
    logic [31:0]      unit_res;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic             busy;
    logic [CNT_W-1:0] ops_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] res_val = 32'h0;
    int          res_lat = 1;
    int          age     = 0;

    fpu_seq #(
        .TAG_W    (TAG_W),
        .CNT_W    (CNT_W),
        .LAT_ADD  (2),
        .LAT_MUL  (2),
        .LAT_DIV  (4),
        .LAT_SQRT (4),
        .LAT_CVT  (2),
        .LAT_MISC (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_src0     (in_src0),
        .in_src1     (in_src1),
        .in_tag      (in_tag),
        .flush       (flush),
        .unit_op     (unit_op),
        .unit_src0   (unit_src0),
        .unit_src1   (unit_src1),
        .unit_res    (unit_res),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .busy        (busy),
        .ops_done    (ops_done)
    );

    always #5 clk = ~clk;

    // Unit model: age is 0 in the first cycle after acceptance, so the result
    // settles in the cycle the sequencer should sample it (cycle T+res_lat).
    always @(posedge clk) begin
        if (in_valid && in_ready) age <= 0;
        else if (age < 1000)      age <= age + 1;
    end
    assign unit_res = (age + 1 >= res_lat) ? res_val : 32'hDEADBEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_src0  = a;
        in_src1  = b;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles after the accepting edge until out_valid; 50 means it never came.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_cmp++;
        if ({out_valid, busy, out_illegal} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags got %b want 000", {out_valid, busy, out_illegal});
        end
        n_cmp++;
        if (ops_done !== 4'h0 || out_result !== 32'h0 || out_tag !== 4'h0) begin
            n_err++; $display("FAIL reset_out got ops=%h res=%h tag=%h want 0", ops_done, out_result, out_tag);
        end
        n_cmp++;
        if (unit_op !== 4'h0 || unit_src0 !== 32'h0 || unit_src1 !== 32'h0) begin
            n_err++; $display("FAIL reset_unit got op=%h a=%h b=%h want 0", unit_op, unit_src0, unit_src1);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fadd();
        int n;
        res_val = 32'h40400000;
        res_lat = 2;
        issue(4'd0, 32'h3F800000, 32'h40000000, 4'd5);
        n_cmp++;
        if (busy !== 1'b1 || unit_op !== 4'd0 || unit_src0 !== 32'h3F800000 || unit_src1 !== 32'h40000000) begin
            n_err++; $display("FAIL fadd_issue got busy=%b op=%h a=%h b=%h", busy, unit_op, unit_src0, unit_src1);
        end
        wait_valid(n);
        n_cmp++;
        if (n !== 2) begin n_err++; $display("FAIL fadd_latency got %0d want 2", n); end
        n_cmp++;
        if (out_result !== 32'h40400000 || out_tag !== 4'd5 || out_illegal !== 1'b0) begin
            n_err++; $display("FAIL fadd_result got %h tag %h ill %b want 40400000 tag 5 ill 0", out_result, out_tag, out_illegal);
        end
        handshake();
        n_cmp++;
        if (ops_done !== 4'd1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL fadd_hs got ops=%0d v=%b busy=%b want 1 0 0", ops_done, out_valid, busy);
        end
    endtask

    task automatic test_stall();
        int n;
        res_val = 32'h40400000;
        res_lat = 4;
        issue(4'd3, 32'h40C00000, 32'h40000000, 4'd9);
        wait_valid(n);
        n_cmp++;
        if (n !== 4) begin n_err++; $display("FAIL fdiv_latency got %0d want 4", n); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'h40400000 ||
                out_tag !== 4'd9 || ops_done !== 4'd1) begin
                n_err++;
                $display("FAIL fdiv_hold[%0d] got v=%b rdy=%b res=%h tag=%h ops=%0d want 1 0 40400000 9 1",
                         i, out_valid, in_ready, out_result, out_tag, ops_done);
            end
            tick();
        end
        handshake();
        n_cmp++;
        if (ops_done !== 4'd2 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL fdiv_hs got ops=%0d v=%b want 2 0", ops_done, out_valid);
        end
    endtask

    task automatic test_compare_illegal();
        int n;
        res_val = 32'hFFFFFFFF;
        res_lat = 1;
        issue(4'd8, 32'h3F800000, 32'h3F800000, 4'd3);
        wait_valid(n);
        n_cmp++;
        if (n !== 1 || out_result !== 32'h00000001) begin
            n_err++; $display("FAIL feq got lat=%0d res=%h want 1 00000001", n, out_result);
        end
        handshake();
        issue(4'd14, 32'h11111111, 32'h22222222, 4'd7);
        n_cmp++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== 32'h0 || out_tag !== 4'd7) begin
            n_err++; $display("FAIL illegal got v=%b ill=%b res=%h tag=%h want 1 1 0 7", out_valid, out_illegal, out_result, out_tag);
        end
        n_cmp++;
        if (unit_op !== 4'd8 || unit_src0 !== 32'h3F800000) begin
            n_err++; $display("FAIL illegal_unit got op=%h a=%h want 8 3f800000", unit_op, unit_src0);
        end
        handshake();
        n_cmp++;
        if (ops_done !== 4'd4) begin n_err++; $display("FAIL illegal_hs got %0d want 4", ops_done); end
    endtask

    task automatic test_back_to_back();
        int n;
        res_val = 32'h12345678;
        res_lat = 1;
        issue(4'd5, 32'h12345678, 32'h00000000, 4'd1);
        wait_valid(n);
        n_cmp++;
        if (n !== 1 || out_result !== 32'h12345678 || out_tag !== 4'd1) begin
            n_err++; $display("FAIL sgnj got lat=%0d res=%h tag=%h want 1 12345678 1", n, out_result, out_tag);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 4'd2;
        in_src0   = 32'h40000000;
        in_src1   = 32'h40400000;
        in_tag    = 4'd2;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", in_ready); end
        res_val = 32'h40C00000;
        res_lat = 2;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (ops_done !== 4'd5 || out_valid !== 1'b0 || busy !== 1'b1 || unit_op !== 4'd2) begin
            n_err++; $display("FAIL b2b_accept got ops=%0d v=%b busy=%b op=%h want 5 0 1 2", ops_done, out_valid, busy, unit_op);
        end
        wait_valid(n);
        n_cmp++;
        if (n !== 2 || out_result !== 32'h40C00000 || out_tag !== 4'd2) begin
            n_err++; $display("FAIL fmul got lat=%0d res=%h tag=%h want 2 40c00000 2", n, out_result, out_tag);
        end
        handshake();
        n_cmp++;
        if (ops_done !== 4'd6) begin n_err++; $display("FAIL fmul_hs got %0d want 6", ops_done); end
    endtask

    task automatic test_flush();
        int n;
        int seen;
        res_val = 32'h3FB504F3;
        res_lat = 4;
        issue(4'd4, 32'h40000000, 32'h0, 4'hA);
        tick();
        tick();
        flush = 1'b1;
        in_valid = 1'b1;
        in_op = 4'd0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_idle got busy=%b v=%b want 0 0", busy, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0 || ops_done !== 4'd6) begin
            n_err++; $display("FAIL flush_quiet got valid_cycles=%0d ops=%0d want 0 6", seen, ops_done);
        end
        // Flush of a held result while the consumer is ready: not counted.
        issue(4'd13, 32'h0, 32'h0, 4'd4);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (ops_done !== 4'd6 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_done got ops=%0d v=%b want 6 0", ops_done, out_valid);
        end
        res_val = 32'h40400000;
        res_lat = 2;
        issue(4'd1, 32'h40A00000, 32'h40000000, 4'd6);
        wait_valid(n);
        n_cmp++;
        if (n !== 2 || out_result !== 32'h40400000 || out_tag !== 4'd6) begin
            n_err++; $display("FAIL after_flush got lat=%0d res=%h tag=%h want 2 40400000 6", n, out_result, out_tag);
        end
        handshake();
        n_cmp++;
        if (ops_done !== 4'd7) begin n_err++; $display("FAIL after_flush_hs got %0d want 7", ops_done); end
    endtask

    task automatic test_async_reset();
        res_lat = 2;
        issue(4'd2, 32'h40000000, 32'h40000000, 4'd8);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, busy} !== 2'b00 || ops_done !== 4'd0 || unit_op !== 4'd0 ||
            unit_src0 !== 32'h0 || out_tag !== 4'd0) begin
            n_err++; $display("FAIL async_rst got v=%b busy=%b ops=%0d op=%h a=%h tag=%h want all 0",
                              out_valid, busy, ops_done, unit_op, unit_src0, out_tag);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) begin
            issue(4'd15, 32'h0, 32'h0, 4'd0);
            handshake();
        end
        n_cmp++;
        if (ops_done !== 4'hF) begin n_err++; $display("FAIL wrap_pre got %h want f", ops_done); end
        issue(4'd15, 32'h0, 32'h0, 4'd0);
        handshake();
        n_cmp++;
        if (ops_done !== 4'h0) begin n_err++; $display("FAIL wrap got %h want 0", ops_done); end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_src0   = '0;
        in_src1   = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_fadd();
        test_stall();
        test_compare_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
